// File: rtl/mem_write_monitor.sv
// mem_write_monitor: snoops MMU writes into per-window FIFOs drained round-robin onto one ready/valid stream.
// Define MWMON_HALT_EN to build the sticky tohost halt detector.
module mem_write_monitor #(
  parameter int NCH = 2,
  parameter int DEPTH = 16,
  parameter int DW = 32,
  parameter logic [NCH*32-1:0] CH_BASE = {32'h4000_0000, 32'h1000_0000},
  parameter logic [NCH*32-1:0] CH_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0},
  parameter logic [31:0] HALT_ADDR = 32'h8000_1000,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [31:0]     w_mem_paddr,
  input  logic            w_mem_we,
  input  logic [DW-1:0]   w_mem_wdata,
  output logic            w_tx_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [CW-1:0]   o_ch,
  output logic [DW-1:0]   o_data,
  output logic [NCH*16-1:0] o_drop_cnt,
  output logic            o_halt,
  output logic [DW-1:0]   o_halt_code
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, GRANT} st_t;
  st_t st, st_n;
  logic [DW-1:0] mem [NCH][DEPTH];
  logic [AW-1:0] wptr [NCH];
  logic [AW-1:0] rptr [NCH];
  logic [AW:0] cnt [NCH];
  logic [15:0] drop [NCH];
  logic [CW-1:0] rr, hit_ch, sel, ch_n;
  logic [DW-1:0] data_n;
  logic hit, found, pop;
  assign o_valid = st == GRANT;
  assign pop = o_valid && i_ready;
  // descending scan so the lowest matching window wins
  always_comb begin
    hit = 1'b0;
    hit_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if ((w_mem_paddr & CH_MASK[i*32 +: 32]) == CH_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        hit_ch = CW'(i);
      end
  end
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (cnt[(int'(rr) + k) % NCH] != '0) begin
        found = 1'b1;
        sel = CW'((int'(rr) + k) % NCH);
      end
  end
  always_comb begin
    w_tx_ready = 1'b1;
    for (int i = 0; i < NCH; i++) w_tx_ready &= cnt[i] != (AW+1)'(DEPTH);
  end
  always_comb begin
    st_n = st;
    ch_n = o_ch;
    data_n = o_data;
    if (st == IDLE && found) begin
      st_n = GRANT;
      ch_n = sel;
      data_n = mem[sel][rptr[sel]];
    end else if (pop) st_n = IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st <= IDLE;
      o_ch <= '0;
      o_data <= '0;
      rr <= '0;
    end else begin
      st <= st_n;
      o_ch <= ch_n;
      o_data <= data_n;
      if (pop) rr <= (o_ch == CW'(NCH - 1)) ? '0 : o_ch + 1'b1;
    end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic push, full, deq;
    assign full = cnt[c] == (AW+1)'(DEPTH);
    assign push = w_mem_we && hit && hit_ch == CW'(c);
    assign deq = pop && o_ch == CW'(c);
    always_ff @(posedge CLK or posedge RST)
      if (RST) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c] <= '0;
        drop[c] <= '0;
      end else begin
        if (push && !full) wptr[c] <= wptr[c] + 1'b1;
        if (deq) rptr[c] <= rptr[c] + 1'b1;
        cnt[c] <= cnt[c] + (AW+1)'(push && !full) - (AW+1)'(deq);
        if (push && full && drop[c] != 16'hFFFF) drop[c] <= drop[c] + 1'b1;
      end
    always_ff @(posedge CLK)
      if (push && !full) mem[c][wptr[c]] <= w_mem_wdata;
    assign o_drop_cnt[c*16 +: 16] = drop[c];
  end
`ifdef MWMON_HALT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      o_halt <= 1'b0;
      o_halt_code <= '0;
    end else if (!o_halt && w_mem_we && w_mem_paddr == HALT_ADDR && w_mem_wdata != '0) begin
      o_halt <= 1'b1;
      o_halt_code <= w_mem_wdata;
`ifndef SYNTHESIS
      $display("HALT code=%x", w_mem_wdata);
`endif
    end
`else
  assign o_halt = 1'b0;
  assign o_halt_code = '0;
`endif
endmodule
